// File: rtl/playbus_pkg.sv
// Shared types for the PlayBus transfer sequencer: FSM states, source/sink
// codes and the request legality check.
package playbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_ROM  = 2'b01,
    SRC_RAM  = 2'b10,
    SRC_SW   = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'b00,
    DST_RAM  = 2'b01,
    DST_LED  = 2'b10
  } dst_e;

  // Count is passed zero-extended so the check works for any ADDR_W.
  localparam int CNT_ARG_W = 16;

  // A RAM-to-RAM move would need RAMO and RAMW together, which the bus cannot do.
  function automatic logic req_legal(input logic [1:0]           s,
                                     input logic [1:0]           d,
                                     input logic [CNT_ARG_W-1:0] c);
    logic dst_ok;
    dst_ok = (d == DST_RAM) || (d == DST_LED);
    return (s != SRC_NONE) && dst_ok && (c != '0) &&
           !((s == SRC_RAM) && (d == DST_RAM));
  endfunction

endpackage

// File: rtl/playbus_seq.sv
// Break-before-make bus transfer sequencer: moves 1..8 words from one PlayBus
// source to one sink, generating the enables, strobes and address.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for go; operands latched on a legal request
// S_SETUP  | source enabled, address settling
// S_STROBE | source enabled, sink strobe high for one cycle
// S_HOLD   | source still enabled after the capture edge
// S_GAP    | bus idle for GAP cycles; address/count advance on the last
// S_DONE   | one-cycle done pulse, then back to idle
module playbus_seq
  import playbus_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              go,
  input  logic              abort,
  input  logic [1:0]        src,
  input  logic [1:0]        dst,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] address,
  output logic              ROMO,
  output logic              RAMO,
  output logic              SWBEN,
  output logic              RAMW,
  output logic              LEDLTCH,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  state_e           state, state_nx;
  logic [1:0]       src_q, dst_q;
  logic [1:0]       src_sel, dst_sel;
  logic [CNT_W-1:0] words_q;
  logic [1:0]       gap_cnt;
  logic             accept, reject, last_gap;
  logic             oe_nx, stb_nx;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    last_gap = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          if (req_legal(src, dst, CNT_ARG_W'(count))) begin
            accept   = 1'b1;
            state_nx = S_SETUP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_SETUP:  state_nx = S_STROBE;
      S_STROBE: state_nx = S_HOLD;
      S_HOLD:   state_nx = S_GAP;
      S_GAP: begin
        if (gap_cnt == 2'd0) begin
          last_gap = 1'b1;
          state_nx = (words_q == CNT_W'(1)) ? S_DONE : S_SETUP;
        end
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    // Abort freezes the address, so the gap-end advance is suppressed too.
    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      last_gap = 1'b0;
    end

    // Outputs are registered from the next state, so a fresh request must
    // select its source straight from the inputs on the accepting edge.
    src_sel = accept ? src : src_q;
    dst_sel = accept ? dst : dst_q;
    oe_nx   = (state_nx == S_SETUP) || (state_nx == S_STROBE) || (state_nx == S_HOLD);
    stb_nx  = (state_nx == S_STROBE);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      src_q   <= SRC_NONE;
      dst_q   <= DST_NONE;
      words_q <= '0;
      gap_cnt <= 2'd0;
      address <= '0;
      ROMO    <= 1'b0;
      RAMO    <= 1'b0;
      SWBEN   <= 1'b0;
      RAMW    <= 1'b0;
      LEDLTCH <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        src_q   <= src;
        dst_q   <= dst;
        words_q <= count;
        address <= start_addr;
        err     <= 1'b0;
      end else if (reject) begin
        err <= 1'b1;
      end

      if ((state_nx == S_GAP) && (state != S_GAP)) begin
        gap_cnt <= 2'(GAP - 1);
      end else if ((state == S_GAP) && (gap_cnt != 2'd0)) begin
        gap_cnt <= gap_cnt - 2'd1;
      end

      if (last_gap) begin
        address <= address + ADDR_W'(1);
        words_q <= words_q - CNT_W'(1);
      end

      ROMO    <= oe_nx && (src_sel == SRC_ROM);
      RAMO    <= oe_nx && (src_sel == SRC_RAM);
      SWBEN   <= oe_nx && (src_sel == SRC_SW);
      RAMW    <= stb_nx && (dst_sel == DST_RAM);
      LEDLTCH <= stb_nx && (dst_sel == DST_LED);
      busy    <= oe_nx || (state_nx == S_GAP);
      done    <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_playbus_seq.sv
// Scoreboard bench for playbus_seq with a behavioural PlayBus level-0 datapath
// (EPROM, RAM, switch buffer, LED latch) hung off the generated strobes.
module tb_playbus_seq;

  localparam logic [1:0] S_ROM = 2'b01, S_RAM = 2'b10, S_SW = 2'b11;
  localparam logic [1:0] D_RAM = 2'b01, D_LED = 2'b10;
  localparam logic [1:0] K_RAM = 2'd0, K_LED = 2'd1, K_DONE = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [2:0] addr;
    logic [3:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_reset, go, abort;
  logic [1:0] src, dst;
  logic [2:0] start_addr;
  logic [3:0] count;
  logic [2:0] address;
  logic       ROMO, RAMO, SWBEN, RAMW, LEDLTCH, busy, done, err;

  logic [3:0] eprom [8];
  logic [3:0] ram [8];
  logic [3:0] sw0;
  logic [3:0] led_q;
  logic [3:0] bus;
  logic       contention;
  logic       mon_en = 1'b0;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  playbus_seq #(.ADDR_W(3), .GAP(1)) dut (
    .clk(clk), .n_reset(n_reset), .go(go), .abort(abort),
    .src(src), .dst(dst), .start_addr(start_addr), .count(count),
    .address(address), .ROMO(ROMO), .RAMO(RAMO), .SWBEN(SWBEN),
    .RAMW(RAMW), .LEDLTCH(LEDLTCH), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus = 4'h0;
    if (ROMO)  bus = eprom[address];
    if (RAMO)  bus = ram[address];
    if (SWBEN) bus = sw0;
    contention = ($countones({ROMO, RAMO, SWBEN}) > 1);
  end

  always @(posedge clk) begin
    if (RAMW)    ram[address] <= bus;
    if (LEDLTCH) led_q <= bus;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [2:0] a, input logic [3:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input ev_t obs);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected actual_kind=%0d addr=%0d data=%0h expected=none",
               obs.kind, obs.addr, obs.data);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(obs.kind), 32'(e.kind));
      if (e.kind != K_DONE) begin
        check("sb_addr", 32'(obs.addr), 32'(e.addr));
        check("sb_data", 32'(obs.data), 32'(e.data));
      end
    end
  endtask

  // Monitor: bus invariants every cycle, strobe/done events against the queue.
  always @(negedge clk) begin
    ev_t obs;
    if (mon_en) begin
      check("src_onehot", 32'($countones({ROMO, RAMO, SWBEN}) <= 1), 1);
      check("strobe_has_oe", 32'(!(RAMW || LEDLTCH) || (ROMO || RAMO || SWBEN)), 1);
      check("ramw_ramo", 32'(RAMW & RAMO), 0);
      check("no_contention", 32'(contention), 0);
      if (RAMW || LEDLTCH) begin
        obs.kind = RAMW ? K_RAM : K_LED;
        obs.addr = address;
        obs.data = bus;
        sb_compare(obs);
      end
      if (done) begin
        obs.kind = K_DONE; obs.addr = 3'd0; obs.data = 4'h0;
        sb_compare(obs);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] s, input logic [1:0] d,
                       input logic [2:0] a, input logic [3:0] c);
    src = s; dst = d; start_addr = a; count = c; go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_n, output int oe_n, output int first_stb);
    n = 0; busy_n = 0; oe_n = 0; first_stb = -1;
    while (done !== 1'b1 && n < 100) begin
      if (busy) busy_n++;
      if (ROMO || RAMO || SWBEN) oe_n++;
      if ((RAMW || LEDLTCH) && first_stb < 0) first_stb = n;
      tick();
      n++;
    end
  endtask

  initial begin
    int n, busy_n, oe_n, first_stb, stb;
    logic seen;

    for (int i = 0; i < 8; i++) begin
      eprom[i] = 4'h8 | 4'(i);
      ram[i]   = 4'h0;
    end
    sw0 = 4'hA; led_q = 4'h0;
    n_reset = 1'b0; go = 1'b1; abort = 1'b1;
    src = S_ROM; dst = D_LED; start_addr = 3'd3; count = 4'd2;

    // Reset overrides go and abort.
    tick(); tick();
    check("rst_address", 32'(address), 0);
    check("rst_outputs", 32'({ROMO, RAMO, SWBEN, RAMW, LEDLTCH}), 0);
    check("rst_flags", 32'({busy, done, err}), 0);
    go = 1'b0; abort = 1'b0;
    n_reset = 1'b1;
    mon_en = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 0);

    // ROM -> LED, one word at address 5.
    push(K_LED, 3'd5, 4'hD);
    push(K_DONE, 3'd0, 4'h0);
    start(S_ROM, D_LED, 3'd5, 4'd1);
    check("t1_setup_oe", 32'({ROMO, RAMO, SWBEN}), 32'b100);
    check("t1_setup_addr", 32'(address), 5);
    check("t1_setup_nostb", 32'(LEDLTCH), 0);
    wait_done(n, busy_n, oe_n, first_stb);
    check("t1_done_latency", 32'(n), 4);
    check("t1_rom_cycles", 32'(oe_n), 3);
    check("t1_strobe_pos", 32'(first_stb), 1);
    check("t1_busy_at_done", 32'(busy), 0);
    tick();
    check("t1_led", 32'(led_q), 32'h0D);
    check("t1_done_pulse", 32'(done), 0);

    // SW -> RAM, three words wrapping 6,7,0.
    push(K_RAM, 3'd6, 4'hA);
    push(K_RAM, 3'd7, 4'hA);
    push(K_RAM, 3'd0, 4'hA);
    push(K_DONE, 3'd0, 4'h0);
    start(S_SW, D_RAM, 3'd6, 4'd3);
    wait_done(n, busy_n, oe_n, first_stb);
    check("t2_done_latency", 32'(n), 12);
    check("t2_busy_cycles", 32'(busy_n), 12);
    check("t2_oe_cycles", 32'(oe_n), 9);
    tick();
    check("t2_ram6", 32'(ram[6]), 32'hA);
    check("t2_ram7", 32'(ram[7]), 32'hA);
    check("t2_ram0", 32'(ram[0]), 32'hA);
    check("t2_ram1_untouched", 32'(ram[1]), 0);

    // RAM -> LED, reading back across the wrap.
    push(K_LED, 3'd7, 4'hA);
    push(K_LED, 3'd0, 4'hA);
    push(K_DONE, 3'd0, 4'h0);
    start(S_RAM, D_LED, 3'd7, 4'd2);
    check("t2b_setup_oe", 32'({ROMO, RAMO, SWBEN}), 32'b010);
    wait_done(n, busy_n, oe_n, first_stb);
    check("t2b_done_latency", 32'(n), 8);
    tick();
    check("t2b_led", 32'(led_q), 32'hA);

    // Illegal requests set err and never touch the bus.
    start(S_RAM, D_RAM, 3'd1, 4'd2);
    check("t3_err_ramram", 32'(err), 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= ROMO | RAMO | SWBEN | RAMW | LEDLTCH | busy;
      tick();
    end
    start(S_ROM, D_LED, 3'd1, 4'd0);
    check("t3_err_count0", 32'(err), 1);
    start(S_ROM, 2'b11, 3'd1, 4'd1);
    check("t3_err_dst11", 32'(err), 1);
    for (int i = 0; i < 4; i++) begin
      seen |= ROMO | RAMO | SWBEN | RAMW | LEDLTCH | busy;
      tick();
    end
    check("t3_no_activity", 32'(seen), 0);
    push(K_LED, 3'd0, 4'h8);
    push(K_DONE, 3'd0, 4'h0);
    start(S_ROM, D_LED, 3'd0, 4'd1);
    check("t3_err_cleared", 32'(err), 0);
    check("t3_accepted", 32'(busy), 1);
    wait_done(n, busy_n, oe_n, first_stb);
    check("t3_done_latency", 32'(n), 4);
    tick();

    // Abort in STROBE of word 2 of 4; a stray go mid-transfer is ignored.
    push(K_LED, 3'd2, 4'hA);
    push(K_LED, 3'd3, 4'hB);
    start(S_ROM, D_LED, 3'd2, 4'd4);
    stb = 0; n = 0;
    while (stb < 2 && n < 40) begin
      if (LEDLTCH) stb++;
      if (stb < 2) begin
        if (n == 1) begin
          go = 1'b1; src = S_SW; dst = D_RAM; start_addr = 3'd0; count = 4'd1;
        end else begin
          go = 1'b0;
        end
        tick();
        n++;
      end
    end
    go = 1'b0;
    check("t4_reached_word2", 32'(stb), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_outputs_off", 32'({ROMO, RAMO, SWBEN, RAMW, LEDLTCH}), 0);
    check("t4_busy_off", 32'(busy), 0);
    check("t4_addr_held", 32'(address), 3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= done | busy;
      tick();
    end
    check("t4_no_done", 32'(seen), 0);
    push(K_LED, 3'd7, 4'hF);
    push(K_DONE, 3'd0, 4'h0);
    start(S_ROM, D_LED, 3'd7, 4'd1);
    check("t4_fresh_go", 32'(busy), 1);
    wait_done(n, busy_n, oe_n, first_stb);
    check("t4_fresh_latency", 32'(n), 4);
    tick();

    // Reset during HOLD; go held high during reset is ignored.
    push(K_RAM, 3'd1, 4'hA);
    start(S_SW, D_RAM, 3'd1, 4'd2);
    tick();
    tick();
    check("t5_in_hold", 32'({SWBEN, RAMW}), 32'b10);
    n_reset = 1'b0; go = 1'b1;
    tick();
    check("t5_addr_zero", 32'(address), 0);
    check("t5_outputs_off", 32'({ROMO, RAMO, SWBEN, RAMW, LEDLTCH, busy, done, err}), 0);
    tick();
    n_reset = 1'b1; go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= busy | done | SWBEN | RAMW;
    end
    check("t5_stays_idle", 32'(seen), 0);
    check("t5_addr_still_zero", 32'(address), 0);

    mon_en = 1'b0;
    check("sb_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
